// File: rtl/pit_cfg_arbiter_pkg.sv
// Shared types and helpers for the minipit configuration arbiter.
// Holds the FSM encoding and the round-robin pick function.
package pit_pkg;

    localparam int PIT_COUNT_W = 16;
    localparam int MAX_REQ     = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } pit_state_e;

    // First set bit of valid, starting just above last_grant and wrapping modulo nreq.
    // The scan runs from the farthest offset down to the nearest, so the nearest
    // valid requester is the last one written and therefore wins.
    function automatic int rr_pick(input logic [MAX_REQ-1:0] valid,
                                   input int last_grant,
                                   input int nreq);
        int idx;
        rr_pick = 0;
        for (int k = MAX_REQ; k >= 1; k--) begin
            if (k <= nreq) begin
                idx = (last_grant + k) % nreq;
                if (valid[idx[1:0]]) rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/pit_cfg_arbiter_if.sv
// Requester-side and timer-side signals of the minipit configuration arbiter.
// The master modport belongs to the requesters and the timer; the slave modport belongs to the arbiter.
interface pit_cfg_arbiter_if #(
    parameter int NREQ = 2
);
    import pit_pkg::*;
    localparam int OWNER_W = $clog2(NREQ);

    logic [NREQ-1:0]                  req_valid;
    logic [NREQ-1:0]                  req_ready;
    logic [NREQ-1:0][PIT_COUNT_W-1:0] req_count;
    logic [NREQ-1:0]                  req_repeating;
    logic [NREQ-1:0]                  req_divider_on;
    logic                             pit_write_enable;
    logic [7:0]                       pit_counter_high;
    logic [7:0]                       pit_counter_low;
    logic                             pit_repeating;
    logic                             pit_divider_on;
    logic                             pit_interrupting;
    logic                             irq_pending;
    logic [OWNER_W-1:0]               irq_owner;
    logic                             irq_clear;
    logic                             busy;

    modport master (
        output req_valid, req_count, req_repeating, req_divider_on,
        output pit_interrupting, irq_clear,
        input  req_ready, pit_write_enable, pit_counter_high, pit_counter_low,
        input  pit_repeating, pit_divider_on, irq_pending, irq_owner, busy
    );

    modport slave (
        input  req_valid, req_count, req_repeating, req_divider_on,
        input  pit_interrupting, irq_clear,
        output req_ready, pit_write_enable, pit_counter_high, pit_counter_low,
        output pit_repeating, pit_divider_on, irq_pending, irq_owner, busy
    );

endinterface

// File: rtl/pit_cfg_arbiter_rr.sv
// Combinational round-robin picker: chooses the next requester after last_i.
module rr_arbiter
    import pit_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int OWNER_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]    valid_i,
    input  logic [OWNER_W-1:0] last_i,
    output logic [OWNER_W-1:0] grant_o,
    output logic               any_o
);

    assign any_o   = |valid_i;
    assign grant_o = OWNER_W'(rr_pick(MAX_REQ'(valid_i), int'(last_i), NREQ));

endmodule

// File: rtl/pit_cfg_arbiter.sv
// Shares one minipit timer between NREQ config requesters: round-robin grant,
// write_enable sequencing, owner tracking and a sticky owner-tagged interrupt flag.
module pit_cfg_arbiter
    import pit_pkg::*;
#(
    parameter  int NREQ         = 2,
    parameter  int WRITE_CYCLES = 1,
    localparam int OWNER_W      = $clog2(NREQ)
) (
    input logic              clk,
    input logic              reset,
    pit_cfg_arbiter_if.slave bus
);

    pit_state_e         state_q, state_d;
    logic [3:0]         wcnt_q, wcnt_d;
    logic [OWNER_W-1:0] last_q, last_d;
    logic [OWNER_W-1:0] owner_q, owner_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               rep_q, rep_d;
    logic               div_q, div_d;
    logic               we_q, we_d;
    logic               irq_prev_q;
    logic               irq_pend_q;
    logic [OWNER_W-1:0] irq_owner_q;
    logic [NREQ-1:0]    ready;
    logic [OWNER_W-1:0] grant;
    logic               any_valid;
    logic               irq_edge;

    rr_arbiter #(.NREQ(NREQ), .OWNER_W(OWNER_W)) u_rr (
        .valid_i (bus.req_valid),
        .last_i  (last_q),
        .grant_o (grant),
        .any_o   (any_valid)
    );

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        last_d  = last_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        rep_d   = rep_q;
        div_d   = div_q;
        we_d    = 1'b0;
        ready   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (any_valid) begin
                    ready[grant] = !reset;
                    cnt_d   = bus.req_count[grant];
                    rep_d   = bus.req_repeating[grant];
                    div_d   = bus.req_divider_on[grant];
                    last_d  = grant;
                    owner_d = grant;
                    wcnt_d  = 4'(WRITE_CYCLES);
                    we_d    = 1'b1;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // write_enable is registered, so it stays high while more cycles remain
                if (wcnt_q == 4'd1) begin
                    state_d = ST_IDLE;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                    we_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            last_q  <= OWNER_W'(NREQ - 1);
            owner_q <= '0;
            cnt_q   <= '0;
            rep_q   <= 1'b0;
            div_q   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            rep_q   <= rep_d;
            div_q   <= div_d;
            we_q    <= we_d;
        end
    end

    assign irq_edge = bus.pit_interrupting && !irq_prev_q;

    // A fresh interrupt edge takes priority over a clear in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_prev_q  <= 1'b0;
            irq_pend_q  <= 1'b0;
            irq_owner_q <= '0;
        end else begin
            irq_prev_q <= bus.pit_interrupting;
            if (irq_edge) begin
                irq_pend_q  <= 1'b1;
                irq_owner_q <= owner_q;
            end else if (bus.irq_clear) begin
                irq_pend_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready        = ready;
    assign bus.pit_write_enable = we_q;
    assign bus.pit_counter_high = cnt_q[15:8];
    assign bus.pit_counter_low  = cnt_q[7:0];
    assign bus.pit_repeating    = rep_q;
    assign bus.pit_divider_on   = div_q;
    assign bus.irq_pending      = irq_pend_q;
    assign bus.irq_owner        = irq_owner_q;
    assign bus.busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pit_cfg_arbiter.sv
// Directed bench for pit_cfg_arbiter: three instances with WRITE_CYCLES = 1, 3 and 4 share clock and reset.
module tb_pit_cfg_arbiter;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    pit_cfg_arbiter_if #(.NREQ(2)) if1 ();
    pit_cfg_arbiter_if #(.NREQ(2)) if3 ();
    pit_cfg_arbiter_if #(.NREQ(2)) if4 ();

    pit_cfg_arbiter #(.NREQ(2), .WRITE_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
    pit_cfg_arbiter #(.NREQ(2), .WRITE_CYCLES(3)) dut3 (.clk(clk), .reset(reset), .bus(if3.slave));
    pit_cfg_arbiter #(.NREQ(2), .WRITE_CYCLES(4)) dut4 (.clk(clk), .reset(reset), .bus(if4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic zero_inputs();
        if1.req_valid = '0; if1.req_count = '0; if1.req_repeating = '0; if1.req_divider_on = '0;
        if1.pit_interrupting = 1'b0; if1.irq_clear = 1'b0;
        if3.req_valid = '0; if3.req_count = '0; if3.req_repeating = '0; if3.req_divider_on = '0;
        if3.pit_interrupting = 1'b0; if3.irq_clear = 1'b0;
        if4.req_valid = '0; if4.req_count = '0; if4.req_repeating = '0; if4.req_divider_on = '0;
        if4.pit_interrupting = 1'b0; if4.irq_clear = 1'b0;
    endtask

    // Leaves the bench 1 time unit after a rising edge, reset released, all DUTs idle.
    task automatic reset_all();
        reset = 1'b1;
        zero_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        zero_inputs();
        #1;
        if1.req_valid = 2'b11;
        #1;
        n_checks++; if (if1.req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b exp 00", if1.req_ready); end
        n_checks++; if (if1.pit_write_enable !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b exp 0", if1.pit_write_enable); end
        n_checks++; if ({if1.pit_counter_high, if1.pit_counter_low} !== 16'h0000) begin n_fail++;
            $display("FAIL reset_count: got %h exp 0000", {if1.pit_counter_high, if1.pit_counter_low}); end
        n_checks++; if ({if1.busy, if1.irq_pending, if1.irq_owner, if1.pit_repeating, if1.pit_divider_on} !== 5'b0) begin n_fail++;
            $display("FAIL reset_misc: got %b exp 00000", {if1.busy, if1.irq_pending, if1.irq_owner, if1.pit_repeating, if1.pit_divider_on}); end
        reset_all();
    endtask

    task automatic test_single();
        reset_all();
        if1.req_valid = 2'b01; if1.req_count[0] = 16'h000A; if1.req_repeating[0] = 1'b1;
        #1;
        n_checks++; if (if1.req_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready: got %b exp 01", if1.req_ready); end
        n_checks++; if (if1.busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_k: got %b exp 0", if1.busy); end
        @(posedge clk); #1 if1.req_valid = 2'b00;
        n_checks++; if (if1.pit_write_enable !== 1'b1) begin n_fail++; $display("FAIL single_we_k1: got %b exp 1", if1.pit_write_enable); end
        n_checks++; if (if1.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_k1: got %b exp 1", if1.busy); end
        n_checks++; if ({if1.pit_counter_high, if1.pit_counter_low} !== 16'h000A) begin n_fail++;
            $display("FAIL single_count: got %h exp 000a", {if1.pit_counter_high, if1.pit_counter_low}); end
        n_checks++; if ({if1.pit_repeating, if1.pit_divider_on} !== 2'b10) begin n_fail++;
            $display("FAIL single_flags: got %b exp 10", {if1.pit_repeating, if1.pit_divider_on}); end
        @(posedge clk); #1;
        n_checks++; if ({if1.pit_write_enable, if1.busy} !== 2'b00) begin n_fail++;
            $display("FAIL single_we_k2: got %b exp 00", {if1.pit_write_enable, if1.busy}); end
        n_checks++; if ({if1.pit_counter_high, if1.pit_counter_low} !== 16'h000A) begin n_fail++;
            $display("FAIL single_hold: got %h exp 000a", {if1.pit_counter_high, if1.pit_counter_low}); end
    endtask

    task automatic test_contention();
        logic [1:0]  exp_rdy;
        logic [15:0] exp_cnt;
        reset_all();
        if1.req_valid = 2'b11; if1.req_count[0] = 16'h1111; if1.req_count[1] = 16'hABCD;
        if1.req_divider_on[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_cnt = (i % 2 == 0) ? 16'h1111 : 16'hABCD;
            #1;
            n_checks++; if (if1.req_ready !== exp_rdy) begin n_fail++; $display("FAIL cont_ready[%0d]: got %b exp %b", i, if1.req_ready, exp_rdy); end
            @(posedge clk); #1;
            n_checks++; if ({if1.req_ready, if1.pit_write_enable} !== 3'b001) begin n_fail++;
                $display("FAIL cont_write[%0d]: got rdy,we=%b exp 001", i, {if1.req_ready, if1.pit_write_enable}); end
            n_checks++; if ({if1.pit_counter_high, if1.pit_counter_low, if1.pit_divider_on} !== {exp_cnt, exp_rdy[1]}) begin n_fail++;
                $display("FAIL cont_cfg[%0d]: got %h/%b exp %h/%b", i, {if1.pit_counter_high, if1.pit_counter_low}, if1.pit_divider_on, exp_cnt, exp_rdy[1]); end
            @(posedge clk);
        end
        #1 if1.req_valid = 2'b00;
    endtask

    task automatic test_multi_cycle_write();
        reset_all();
        if3.req_valid = 2'b10; if3.req_count[1] = 16'h1234;
        #1;
        n_checks++; if (if3.req_ready !== 2'b10) begin n_fail++; $display("FAIL w3_ready_k: got %b exp 10", if3.req_ready); end
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            n_checks++; if ({if3.pit_write_enable, if3.req_ready} !== 3'b100) begin n_fail++;
                $display("FAIL w3_we[%0d]: got we,rdy=%b exp 100", i, {if3.pit_write_enable, if3.req_ready}); end
        end
        n_checks++; if ({if3.pit_counter_high, if3.pit_counter_low} !== 16'h1234) begin n_fail++;
            $display("FAIL w3_count: got %h exp 1234", {if3.pit_counter_high, if3.pit_counter_low}); end
        @(posedge clk); #1;
        n_checks++; if ({if3.pit_write_enable, if3.req_ready} !== 3'b010) begin n_fail++;
            $display("FAIL w3_regrant_k4: got we,rdy=%b exp 010", {if3.pit_write_enable, if3.req_ready}); end
        if3.req_count[1] = 16'h0000;
        @(posedge clk); #1 if3.req_valid = 2'b00;
        n_checks++; if ({if3.pit_write_enable, if3.pit_counter_high, if3.pit_counter_low} !== 17'h10000) begin n_fail++;
            $display("FAIL w3_zero_count: got we=%b cnt=%h exp we=1 cnt=0000", if3.pit_write_enable, {if3.pit_counter_high, if3.pit_counter_low}); end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_irq();
        reset_all();
        if1.req_valid = 2'b10; if1.req_count[1] = 16'h0042;
        @(posedge clk); #1 if1.req_valid = 2'b00;
        @(posedge clk); #1 if1.pit_interrupting = 1'b1;
        @(posedge clk); #1 if1.pit_interrupting = 1'b0;
        n_checks++; if ({if1.irq_pending, if1.irq_owner} !== 2'b11) begin n_fail++;
            $display("FAIL irq_set: got pend,owner=%b exp 11", {if1.irq_pending, if1.irq_owner}); end
        if1.irq_clear = 1'b1;
        @(posedge clk); #1 if1.irq_clear = 1'b0;
        n_checks++; if (if1.irq_pending !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b exp 0", if1.irq_pending); end
        // Edge and clear together, then level held with a later clear.
        if1.pit_interrupting = 1'b1; if1.irq_clear = 1'b1;
        @(posedge clk); #1 if1.irq_clear = 1'b0;
        n_checks++; if (if1.irq_pending !== 1'b1) begin n_fail++; $display("FAIL irq_set_wins: got %b exp 1", if1.irq_pending); end
        @(posedge clk); #1 if1.irq_clear = 1'b1;
        @(posedge clk); #1 if1.irq_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (if1.irq_pending !== 1'b0) begin n_fail++; $display("FAIL irq_level_no_reset: got %b exp 0", if1.irq_pending); end
        if1.pit_interrupting = 1'b0;
        @(posedge clk); #1 if1.pit_interrupting = 1'b1;
        @(posedge clk); #1 if1.pit_interrupting = 1'b0;
        if1.req_valid = 2'b01; if1.req_count[0] = 16'h0007;
        @(posedge clk); #1 if1.req_valid = 2'b00;
        n_checks++; if ({if1.irq_pending, if1.irq_owner} !== 2'b11) begin n_fail++;
            $display("FAIL irq_survives_load: got pend,owner=%b exp 11", {if1.irq_pending, if1.irq_owner}); end
        @(posedge clk); #1 if1.pit_interrupting = 1'b1;
        @(posedge clk); #1 if1.pit_interrupting = 1'b0;
        n_checks++; if ({if1.irq_pending, if1.irq_owner} !== 2'b10) begin n_fail++;
            $display("FAIL irq_new_owner: got pend,owner=%b exp 10", {if1.irq_pending, if1.irq_owner}); end
    endtask

    task automatic test_reset_mid_write();
        reset_all();
        if4.req_valid = 2'b10; if4.req_count[1] = 16'h5A5A; if4.req_repeating[1] = 1'b1;
        @(posedge clk); #1 if4.req_valid = 2'b00;
        @(posedge clk); #1;
        n_checks++; if ({if4.pit_write_enable, if4.busy} !== 2'b11) begin n_fail++;
            $display("FAIL rstw_pre: got we,busy=%b exp 11", {if4.pit_write_enable, if4.busy}); end
        reset = 1'b1;
        #1;
        n_checks++; if ({if4.pit_write_enable, if4.busy, if4.pit_repeating} !== 3'b000) begin n_fail++;
            $display("FAIL rstw_async: got we,busy,rep=%b exp 000", {if4.pit_write_enable, if4.busy, if4.pit_repeating}); end
        n_checks++; if ({if4.pit_counter_high, if4.pit_counter_low} !== 16'h0000) begin n_fail++;
            $display("FAIL rstw_count: got %h exp 0000", {if4.pit_counter_high, if4.pit_counter_low}); end
        if4.req_valid = 2'b11;
        #1;
        n_checks++; if (if4.req_ready !== 2'b00) begin n_fail++; $display("FAIL rstw_ready_in_reset: got %b exp 00", if4.req_ready); end
        @(posedge clk); #1 reset = 1'b0;
        #1;
        n_checks++; if (if4.req_ready !== 2'b01) begin n_fail++; $display("FAIL rstw_first_grant: got %b exp 01", if4.req_ready); end
        if4.req_valid = 2'b00;
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        zero_inputs();
        test_reset();
        test_single();
        test_contention();
        test_multi_cycle_write();
        test_irq();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
